// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754 style adder/subtractor with parameterised exponent and
// mantissa widths. Handles one request at a time and holds its result until consumed.
module fp_addsub_param #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] op_a,
  input  logic [EXP_W+MAN_W:0] op_b,
  input  logic                 sub,
  input  logic [1:0]           round_mode,
  input  logic                 start,
  output logic                 ready_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic [EXP_W+MAN_W:0] result,
  output logic [4:0]           flags,
  output logic [2:0]           dbg_state
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam int EW = EXP_W + 1;
  localparam logic [EW-1:0]    EMAX   = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EW-1:0]    EW_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] E_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;

  logic [W-1:0]     a_q, b_q, result_q;
  logic             sub_q, sign_q, eff_sub_q;
  logic [1:0]       rm_q;
  logic [EW-1:0]    exp_q;
  logic [EXP_W-1:0] shift_q;
  logic [SW-1:0]    big_q, small_q, sig_q;
  logic [SW:0]      sum_q;
  logic [4:0]       flags_q;

  // Handshake: a request is taken on an edge with start && ready_out (IDLE only);
  // result/flags/valid_out hold in DONE until the edge with valid_out && ready_in.
  assign ready_out = (state_q == IDLE);
  assign valid_out = (state_q == DONE);
  assign result    = result_q;
  assign flags     = flags_q;
  assign dbg_state = state_q;

  logic             a_s, b_s, a_nan, b_nan, a_inf, b_inf, special, a_big;
  logic [EXP_W-1:0] a_e, b_e, a_ee, b_ee;
  logic [MAN_W-1:0] a_m, b_m;
  logic [SW-1:0]    a_sig, b_sig;
  logic [W-1:0]     spec_res;
  logic [4:0]       spec_flags;

  assign a_s     = a_q[W-1];
  assign b_s     = b_q[W-1] ^ sub_q;
  assign a_e     = a_q[W-2:MAN_W];
  assign b_e     = b_q[W-2:MAN_W];
  assign a_m     = a_q[MAN_W-1:0];
  assign b_m     = b_q[MAN_W-1:0];
  assign a_ee    = (a_e == '0) ? E_ONE : a_e;
  assign b_ee    = (b_e == '0) ? E_ONE : b_e;
  assign a_sig   = {a_e != '0, a_m, 3'b000};
  assign b_sig   = {b_e != '0, b_m, 3'b000};
  assign a_nan   = (&a_e) && (|a_m);
  assign b_nan   = (&b_e) && (|b_m);
  assign a_inf   = (&a_e) && !(|a_m);
  assign b_inf   = (&b_e) && !(|b_m);
  assign special = a_nan || b_nan || a_inf || b_inf;
  assign a_big   = (a_q[W-2:0] >= b_q[W-2:0]);

  always_comb begin
    spec_res   = QNAN;
    spec_flags = '0;
    if (a_nan || b_nan)
      spec_flags = {(a_nan && !a_m[MAN_W-1]) || (b_nan && !b_m[MAN_W-1]), 4'b0000};
    else if (a_inf && b_inf && (a_s != b_s))
      spec_flags = 5'b10000;
    else if (a_inf)
      spec_res = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_res = {b_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end

  // Alignment: bits shifted out of the smaller operand fold into the sticky LSB.
  logic [SW-1:0] al_small, lost_mask;
  logic          al_sticky;
  always_comb begin
    al_small  = '0;
    lost_mask = '0;
    al_sticky = 1'b0;
    if (int'(shift_q) >= MAN_W + 3) begin
      al_sticky = |small_q;
    end else begin
      al_small  = small_q >> shift_q;
      lost_mask = ~({SW{1'b1}} << shift_q);
      al_sticky = |(small_q & lost_mask);
    end
    al_small[0] = al_small[0] | al_sticky;
  end

  logic [SW:0] sum_d;
  assign sum_d = eff_sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                           : ({1'b0, big_q} + {1'b0, small_q});

  int            lz, sh, sh_max;
  logic [SW-1:0] norm_sig;
  logic [EW-1:0] norm_exp;
  always_comb begin
    lz = SW;
    for (int i = 0; i < SW; i++)
      if (sum_q[i]) lz = SW - 1 - i;
    sh_max   = int'(exp_q) - 1;
    sh       = (lz < sh_max) ? lz : sh_max;
    norm_sig = sum_q[SW-1:0] << sh;
    norm_exp = exp_q - EW'(sh);
    if (sum_q[SW]) begin
      norm_sig = {sum_q[SW:2], sum_q[1] | sum_q[0]};
      norm_exp = exp_q + EW_ONE;
    end
  end

  logic             inexact, inc, ovf_inf;
  logic [MAN_W+1:0] rnd;
  logic [EW-1:0]    exp_r;
  logic [MAN_W-1:0] man_r;
  logic [W-1:0]     rnd_res;
  logic [4:0]       rnd_flags;
  always_comb begin
    inexact = |sig_q[2:0];
    inc     = 1'b0;
    case (rm_q)
      2'b00:   inc = sig_q[2] & (sig_q[1] | sig_q[0] | sig_q[3]);
      2'b01:   inc = 1'b0;
      2'b10:   inc = inexact & ~sign_q;
      default: inc = inexact & sign_q;
    endcase
    rnd = {1'b0, sig_q[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    // A carry out of rounding renormalises; a missing hidden bit means subnormal.
    if (rnd[MAN_W+1]) begin
      man_r = rnd[MAN_W:1];
      exp_r = exp_q + EW_ONE;
    end else begin
      man_r = rnd[MAN_W-1:0];
      exp_r = rnd[MAN_W] ? exp_q : '0;
    end
    ovf_inf = (rm_q == 2'b00) || (rm_q == 2'b10 && !sign_q) || (rm_q == 2'b11 && sign_q);
    if (exp_r >= EMAX) begin
      rnd_res   = ovf_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {sign_q, {{(EXP_W-1){1'b1}}, 1'b0}, {MAN_W{1'b1}}};
      rnd_flags = 5'b00101;
    end else begin
      rnd_res   = {sign_q, exp_r[EXP_W-1:0], man_r};
      rnd_flags = {3'b000, (exp_r == '0) && inexact, inexact};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = UNPACK;
      UNPACK:  state_d = special ? DONE : ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (ready_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
      rm_q      <= '0;
      sign_q    <= 1'b0;
      eff_sub_q <= 1'b0;
      exp_q     <= '0;
      shift_q   <= '0;
      big_q     <= '0;
      small_q   <= '0;
      sum_q     <= '0;
      sig_q     <= '0;
      result_q  <= '0;
      flags_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_q   <= op_a;
          b_q   <= op_b;
          sub_q <= sub;
          rm_q  <= round_mode;
        end
        UNPACK: if (special) begin
          result_q <= spec_res;
          flags_q  <= spec_flags;
        end else begin
          sign_q    <= a_big ? a_s : b_s;
          eff_sub_q <= a_s ^ b_s;
          exp_q     <= {1'b0, a_big ? a_ee : b_ee};
          shift_q   <= a_big ? (a_ee - b_ee) : (b_ee - a_ee);
          big_q     <= a_big ? a_sig : b_sig;
          small_q   <= a_big ? b_sig : a_sig;
        end
        ALIGN: small_q <= al_small;
        ADD: begin
          sum_q <= sum_d;
          // Exact cancellation gives +0, or -0 when rounding toward -inf.
          if (sum_d == '0 && eff_sub_q) sign_q <= (rm_q == 2'b11);
        end
        NORM: begin
          sig_q <= norm_sig;
          exp_q <= norm_exp;
        end
        ROUND: begin
          result_q <= rnd_res;
          flags_q  <= rnd_flags;
        end
        default: ;
      endcase
    end
  end
endmodule
